// File: rtl/bus_pack.sv
// Streaming word packer: gathers up to NUM_WORDS narrow words into one wide bus word,
// with early termination on in_last, zero fill above the last word and a one-deep park slot.
module bus_pack #(
   parameter int DAT_WIDTH = 16,
   parameter int SEL_WIDTH = 3,
   localparam int NUM_WORDS = 1 << SEL_WIDTH,
   localparam int TOTAL_DAT = DAT_WIDTH << SEL_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [DAT_WIDTH-1:0]   in_data,
   input  logic                   in_valid,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic [TOTAL_DAT-1:0]   out_data,
   output logic [SEL_WIDTH:0]     out_count,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_WORDS - 1);

   logic [DAT_WIDTH-1:0] word_q [NUM_WORDS];
   logic [DAT_WIDTH-1:0] word_d [NUM_WORDS];
   logic [SEL_WIDTH-1:0] idx_q, idx_d;
   logic                 a_full_q, a_full_d;
   logic [SEL_WIDTH:0]   park_cnt_q, park_cnt_d;
   logic [TOTAL_DAT-1:0] out_data_q, out_data_d;
   logic [SEL_WIDTH:0]   out_count_q, out_count_d;
   logic                 out_valid_q, out_valid_d;

   logic [TOTAL_DAT-1:0] packed_word;
   logic [TOTAL_DAT-1:0] parked_word;
   logic [SEL_WIDTH:0]   final_cnt;
   logic                 out_free;
   logic                 accept;
   logic                 is_final;

   // Completed word seen by a final beat: stored words below idx, the live beat at idx,
   // zeros above so stale data can never leak into a short packet.
   generate
      for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_pack
         localparam logic [SEL_WIDTH-1:0] GI_IDX = SEL_WIDTH'(gi);
         assign packed_word[gi*DAT_WIDTH +: DAT_WIDTH] =
            (GI_IDX < idx_q)  ? word_q[gi] :
            (GI_IDX == idx_q) ? in_data    : '0;
         assign parked_word[gi*DAT_WIDTH +: DAT_WIDTH] = word_q[gi];
      end
   endgenerate

   // Ready depends only on registered state (and reset), never on out_ready.
   assign in_ready  = reset_n & ~a_full_q;
   assign out_free  = ~out_valid_q | out_ready;
   assign accept    = in_valid & in_ready;
   assign is_final  = accept & (in_last | (idx_q == LAST_IDX));
   assign final_cnt = (SEL_WIDTH+1)'(idx_q) + (SEL_WIDTH+1)'(1);

   always_comb begin
      word_d      = word_q;
      idx_d       = idx_q;
      a_full_d    = a_full_q;
      park_cnt_d  = park_cnt_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      out_valid_d = out_valid_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (a_full_q) begin
         if (out_free) begin
            out_data_d  = parked_word;
            out_count_d = park_cnt_q;
            out_valid_d = 1'b1;
            for (int i = 0; i < NUM_WORDS; i++) word_d[i] = '0;
            idx_d       = '0;
            a_full_d    = 1'b0;
         end
      end else if (is_final) begin
         if (out_free) begin
            out_data_d  = packed_word;
            out_count_d = final_cnt;
            out_valid_d = 1'b1;
            for (int i = 0; i < NUM_WORDS; i++) word_d[i] = '0;
            idx_d       = '0;
         end else begin
            // Words above idx are already zero because the register is cleared on every hand-off.
            word_d[idx_q] = in_data;
            a_full_d      = 1'b1;
            park_cnt_d    = final_cnt;
         end
      end else if (accept) begin
         word_d[idx_q] = in_data;
         idx_d         = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_WORDS; i++) word_q[i] <= '0;
         idx_q       <= '0;
         a_full_q    <= 1'b0;
         park_cnt_q  <= '0;
         out_data_q  <= '0;
         out_count_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         word_q      <= word_d;
         idx_q       <= idx_d;
         a_full_q    <= a_full_d;
         park_cnt_q  <= park_cnt_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_valid = out_valid_q;

endmodule
